// File: rtl/fll_cfg_sequencer.sv
// FLL configuration sequencer.
// Arbitrates between a one-shot boot sequence (write CFG2, write CFG1, wait
// for lock) and single software register transfers towards an FLL register
// port. Every FLL transfer and the lock wait are bounded by saturating counters.
module fll_cfg_sequencer #(
    parameter logic [31:0] BOOT_CFG2    = 32'h0000_0000,
    parameter logic [31:0] BOOT_CFG1    = 32'h0000_0100,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned ACK_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        boot_start_i,
    input  logic        sw_req_i,
    input  logic        sw_wrn_i,
    input  logic [1:0]  sw_add_i,
    input  logic [31:0] sw_wdata_i,
    output logic        sw_gnt_o,
    output logic        sw_ack_o,
    output logic [31:0] sw_rdata_o,
    output logic        sw_err_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_wdata_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_rdata_i,
    input  logic        fll_lock_i,
    output logic        busy_o,
    output logic        boot_done_o,
    output logic        timeout_o
);

    localparam int XW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [XW-1:0] ACK_LAST  = XW'(ACK_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SW_XFER   = 3'd1,
        BOOT_WR2  = 3'd2,
        BOOT_WR1  = 3'd3,
        WAIT_LOCK = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            boot_pend;
    logic [XW-1:0]   xfer_cnt;
    logic [LW-1:0]   lock_cnt;
    logic            in_xfer;
    logic            ack_hit;
    logic            ack_tmo;
    logic            lock_hit;
    logic            lock_tmo;
    logic            enter;

    assign in_xfer = (state == SW_XFER) || (state == BOOT_WR2) || (state == BOOT_WR1);
    assign enter   = (state_next != state);
    assign busy_o  = (state != IDLE);

    // State register; reset abandons any transfer in flight without retry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, software grant and transfer/lock completion strobes.
    always_comb begin
        state_next = state;
        sw_gnt_o   = 1'b0;
        ack_hit    = 1'b0;
        ack_tmo    = 1'b0;
        lock_hit   = 1'b0;
        lock_tmo   = 1'b0;
        case (state)
            IDLE: begin
                // Boot (new or pended) always wins over a software request.
                if (boot_start_i || boot_pend) begin
                    state_next = BOOT_WR2;
                end else if (sw_req_i) begin
                    sw_gnt_o   = 1'b1;
                    state_next = SW_XFER;
                end
            end
            SW_XFER, BOOT_WR2, BOOT_WR1: begin
                // An ack on the last counted cycle still counts as success.
                if (fll_ack_i) begin
                    ack_hit = 1'b1;
                end else if (xfer_cnt == ACK_LAST) begin
                    ack_tmo = 1'b1;
                end
                if (ack_hit || ack_tmo) begin
                    if (state == BOOT_WR2 && ack_hit) begin
                        state_next = BOOT_WR1;
                    end else if (state == BOOT_WR1 && ack_hit) begin
                        state_next = WAIT_LOCK;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT_LOCK: begin
                if (fll_lock_i) begin
                    lock_hit   = 1'b1;
                    state_next = IDLE;
                end else if (lock_cnt == LOCK_LAST) begin
                    lock_tmo   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Remember a boot request that arrives while busy; it is served from IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_pend <= 1'b0;
        end else if (state == IDLE) begin
            boot_pend <= 1'b0;
        end else if (boot_start_i) begin
            boot_pend <= 1'b1;
        end
    end

    // Transfer and lock counters: clear on state entry, then count up and saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xfer_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            if (enter) begin
                xfer_cnt <= '0;
            end else if (in_xfer && xfer_cnt != ACK_LAST) begin
                xfer_cnt <= xfer_cnt + XW'(1);
            end
            if (enter) begin
                lock_cnt <= '0;
            end else if (state == WAIT_LOCK && lock_cnt != LOCK_LAST) begin
                lock_cnt <= lock_cnt + LW'(1);
            end
        end
    end

    // FLL request/command registers, software response and sticky status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fll_req_o   <= 1'b0;
            fll_wrn_o   <= 1'b0;
            fll_add_o   <= 2'd0;
            fll_wdata_o <= 32'd0;
            sw_ack_o    <= 1'b0;
            sw_err_o    <= 1'b0;
            sw_rdata_o  <= 32'd0;
            boot_done_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            sw_ack_o  <= 1'b0;
            sw_err_o  <= 1'b0;
            fll_req_o <= (state_next == SW_XFER) || (state_next == BOOT_WR2) ||
                         (state_next == BOOT_WR1);

            // Command fields are loaded once on entry and held until the ack.
            if (sw_gnt_o) begin
                fll_wrn_o   <= sw_wrn_i;
                fll_add_o   <= sw_add_i;
                fll_wdata_o <= sw_wdata_i;
            end else if (enter && state_next == BOOT_WR2) begin
                fll_wrn_o   <= 1'b0;
                fll_add_o   <= 2'd2;
                fll_wdata_o <= BOOT_CFG2;
                boot_done_o <= 1'b0;
            end else if (enter && state_next == BOOT_WR1) begin
                fll_wrn_o   <= 1'b0;
                fll_add_o   <= 2'd1;
                fll_wdata_o <= BOOT_CFG1;
            end

            if (state == SW_XFER && ack_hit) begin
                sw_ack_o <= 1'b1;
                if (fll_wrn_o) begin
                    sw_rdata_o <= fll_rdata_i;
                end
            end
            if (state == SW_XFER && ack_tmo) begin
                sw_ack_o <= 1'b1;
                sw_err_o <= 1'b1;
            end

            if (ack_tmo || lock_tmo) begin
                timeout_o <= 1'b1;
            end
            // A boot that fails a write still counts as finished.
            if ((ack_tmo && state != SW_XFER) || lock_hit || lock_tmo) begin
                boot_done_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fll_cfg_sequencer.sv
// Directed testbench for fll_cfg_sequencer with a small FLL responder model.
module tb_fll_cfg_sequencer;

    localparam logic [31:0] CFG2    = 32'h1234_5678;
    localparam logic [31:0] CFG1    = 32'h0000_0100;
    localparam int          LOCK_TO = 1024;
    localparam int          ACK_TO  = 64;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        boot_start_i;
    logic        sw_req_i;
    logic        sw_wrn_i;
    logic [1:0]  sw_add_i;
    logic [31:0] sw_wdata_i;
    logic        sw_gnt_o;
    logic        sw_ack_o;
    logic [31:0] sw_rdata_o;
    logic        sw_err_o;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_wdata_o;
    logic        fll_ack_i;
    logic [31:0] fll_rdata_i;
    logic        fll_lock_i;
    logic        busy_o;
    logic        boot_done_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    logic [34:0] wlog[$];
    int          ack_dly = 2;
    bit          ack_en  = 1'b1;

    always #5 clk = ~clk;

    fll_cfg_sequencer #(
        .BOOT_CFG2   (CFG2),
        .BOOT_CFG1   (CFG1),
        .LOCK_TIMEOUT(LOCK_TO),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .boot_start_i(boot_start_i),
        .sw_req_i    (sw_req_i),
        .sw_wrn_i    (sw_wrn_i),
        .sw_add_i    (sw_add_i),
        .sw_wdata_i  (sw_wdata_i),
        .sw_gnt_o    (sw_gnt_o),
        .sw_ack_o    (sw_ack_o),
        .sw_rdata_o  (sw_rdata_o),
        .sw_err_o    (sw_err_o),
        .fll_req_o   (fll_req_o),
        .fll_wrn_o   (fll_wrn_o),
        .fll_add_o   (fll_add_o),
        .fll_wdata_o (fll_wdata_o),
        .fll_ack_i   (fll_ack_i),
        .fll_rdata_i (fll_rdata_i),
        .fll_lock_i  (fll_lock_i),
        .busy_o      (busy_o),
        .boot_done_o (boot_done_o),
        .timeout_o   (timeout_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic check_log(input string tag, input int idx, input logic wrn,
                             input logic [1:0] add, input logic [31:0] data);
        logic [34:0] e;
        e = (idx < wlog.size()) ? wlog[idx] : 35'h7_FFFF_FFFF;
        check_val({tag, "_wrn"}, {31'd0, e[34]}, {31'd0, wrn});
        check_val({tag, "_add"}, {30'd0, e[33:32]}, {30'd0, add});
        check_val({tag, "_data"}, e[31:0], data);
    endtask

    task automatic wait_log(input string tag, input int n);
        for (int i = 0; i < 200; i++) begin
            if (wlog.size() >= n) break;
            tick();
        end
        check_val(tag, wlog.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy_o) break;
            tick();
        end
        check_val(tag, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic wait_sw_ack(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sw_ack_o) break;
            tick();
        end
        check_val(tag, {31'd0, sw_ack_o}, 32'd1);
    endtask

    // FLL responder: acks the ack_dly-th cycle of each request and logs the command.
    initial begin
        int req_cyc;
        req_cyc   = 0;
        fll_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (fll_ack_i) begin
                fll_ack_i = 1'b0;
                req_cyc   = 0;
            end else if (fll_req_o && ack_en) begin
                req_cyc++;
                if (req_cyc >= ack_dly) begin
                    fll_ack_i = 1'b1;
                    wlog.push_back({fll_wrn_o, fll_add_o, fll_wdata_o});
                    req_cyc = 0;
                end
            end else begin
                req_cyc = 0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n_ack;
        int n_req;
        bit found;

        rst_i        = 1'b1;
        boot_start_i = 1'b0;
        sw_req_i     = 1'b0;
        sw_wrn_i     = 1'b0;
        sw_add_i     = 2'd0;
        sw_wdata_i   = 32'd0;
        fll_rdata_i  = 32'd0;
        fll_lock_i   = 1'b0;

        // Reset state
        repeat (3) tick();
        check_val("rst_fll_req",   {31'd0, fll_req_o},   32'd0);
        check_val("rst_fll_wrn",   {31'd0, fll_wrn_o},   32'd0);
        check_val("rst_fll_add",   {30'd0, fll_add_o},   32'd0);
        check_val("rst_fll_wdata", fll_wdata_o,          32'd0);
        check_val("rst_sw_ack",    {31'd0, sw_ack_o},    32'd0);
        check_val("rst_sw_err",    {31'd0, sw_err_o},    32'd0);
        check_val("rst_sw_rdata",  sw_rdata_o,           32'd0);
        check_val("rst_boot_done", {31'd0, boot_done_o}, 32'd0);
        check_val("rst_timeout",   {31'd0, timeout_o},   32'd0);
        check_val("rst_busy",      {31'd0, busy_o},      32'd0);
        check_val("rst_gnt",       {31'd0, sw_gnt_o},    32'd0);
        rst_i = 1'b0;
        tick();

        // Boot sequence with lock 10 cycles after the second ack
        ack_en  = 1'b1;
        ack_dly = 2;
        boot_start_i = 1'b1;
        tick();
        boot_start_i = 1'b0;
        check_val("boot_busy",     {31'd0, busy_o},    32'd1);
        check_val("boot_req",      {31'd0, fll_req_o}, 32'd1);
        check_val("boot_wr2_add",  {30'd0, fll_add_o}, 32'd2);
        check_val("boot_wr2_data", fll_wdata_o,        CFG2);
        wait_log("boot_writes", 2);
        repeat (10) tick();
        fll_lock_i = 1'b1;
        wait_idle("boot_idle");
        fll_lock_i = 1'b0;
        check_log("boot_log0", 0, 1'b0, 2'd2, CFG2);
        check_log("boot_log1", 1, 1'b0, 2'd1, CFG1);
        check_val("boot_done",    {31'd0, boot_done_o}, 32'd1);
        check_val("boot_timeout", {31'd0, timeout_o},   32'd0);

        // Software read, ack after 3 cycles
        ack_dly     = 3;
        fll_rdata_i = 32'hDEAD_BEEF;
        sw_req_i    = 1'b1;
        sw_wrn_i    = 1'b1;
        sw_add_i    = 2'd3;
        sw_wdata_i  = 32'd0;
        #1;
        check_val("rd_gnt", {31'd0, sw_gnt_o}, 32'd1);
        tick();
        sw_req_i   = 1'b0;
        sw_wdata_i = 32'hFFFF_FFFF;
        check_val("rd_req", {31'd0, fll_req_o}, 32'd1);
        check_val("rd_add", {30'd0, fll_add_o}, 32'd3);
        check_val("rd_wrn", {31'd0, fll_wrn_o}, 32'd1);
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            if (sw_ack_o) begin
                n_ack++;
                check_val("rd_rdata", sw_rdata_o,            32'hDEAD_BEEF);
                check_val("rd_err",   {31'd0, sw_err_o},     32'd0);
            end
            tick();
        end
        check_val("rd_ack_pulses", n_ack, 32'd1);

        // Software write with a boot request pended during the transfer
        ack_dly     = 4;
        fll_lock_i  = 1'b1;
        fll_rdata_i = 32'h1111_1111;
        base        = wlog.size();
        sw_req_i    = 1'b1;
        sw_wrn_i    = 1'b0;
        sw_add_i    = 2'd1;
        sw_wdata_i  = 32'hCAFE_F00D;
        #1;
        check_val("wr_gnt", {31'd0, sw_gnt_o}, 32'd1);
        tick();
        sw_req_i     = 1'b0;
        boot_start_i = 1'b1;
        tick();
        boot_start_i = 1'b0;
        wait_sw_ack("wr_ack");
        check_val("wr_err",   {31'd0, sw_err_o}, 32'd0);
        check_val("wr_rdata", sw_rdata_o,        32'hDEAD_BEEF);
        wait_log("pend_writes", base + 3);
        wait_idle("pend_idle");
        check_log("wr_log",    base,     1'b0, 2'd1, 32'hCAFE_F00D);
        check_log("pend_log0", base + 1, 1'b0, 2'd2, CFG2);
        check_log("pend_log1", base + 2, 1'b0, 2'd1, CFG1);
        check_val("pend_boot_done", {31'd0, boot_done_o}, 32'd1);

        // Boot and software request in the same IDLE cycle
        ack_dly      = 2;
        fll_rdata_i  = 32'h0BAD_F00D;
        base         = wlog.size();
        boot_start_i = 1'b1;
        sw_req_i     = 1'b1;
        sw_wrn_i     = 1'b1;
        sw_add_i     = 2'd0;
        #1;
        check_val("sim_gnt_blocked", {31'd0, sw_gnt_o}, 32'd0);
        tick();
        boot_start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_val("sim_idle_seen", {31'd0, found},       32'd1);
        check_val("sim_gnt_idle",  {31'd0, sw_gnt_o},    32'd1);
        check_val("sim_boot_wrs",  wlog.size() - base,   32'd2);
        check_val("sim_boot_done", {31'd0, boot_done_o}, 32'd1);
        tick();
        sw_req_i = 1'b0;
        wait_sw_ack("sim_ack");
        check_val("sim_rdata", sw_rdata_o, 32'h0BAD_F00D);
        fll_lock_i = 1'b0;
        tick();

        // Ack timeout on a software write
        ack_en     = 1'b0;
        sw_req_i   = 1'b1;
        sw_wrn_i   = 1'b0;
        sw_add_i   = 2'd2;
        sw_wdata_i = 32'h5555_AAAA;
        #1;
        check_val("ato_gnt", {31'd0, sw_gnt_o}, 32'd1);
        tick();
        sw_req_i = 1'b0;
        repeat (ACK_TO - 1) tick();
        check_val("ato_pre_ack",     {31'd0, sw_ack_o},  32'd0);
        check_val("ato_pre_req",     {31'd0, fll_req_o}, 32'd1);
        check_val("ato_pre_timeout", {31'd0, timeout_o}, 32'd0);
        tick();
        check_val("ato_ack",     {31'd0, sw_ack_o},  32'd1);
        check_val("ato_err",     {31'd0, sw_err_o},  32'd1);
        check_val("ato_timeout", {31'd0, timeout_o}, 32'd1);
        check_val("ato_req",     {31'd0, fll_req_o}, 32'd0);
        check_val("ato_busy",    {31'd0, busy_o},    32'd0);
        tick();
        check_val("ato_ack_end",    {31'd0, sw_ack_o},  32'd0);
        check_val("ato_err_end",    {31'd0, sw_err_o},  32'd0);
        check_val("ato_req_next",   {31'd0, fll_req_o}, 32'd0);
        check_val("ato_sticky",     {31'd0, timeout_o}, 32'd1);
        ack_en = 1'b1;

        // Lock timeout, timed from WAIT_LOCK entry
        rst_i = 1'b1;
        tick();
        check_val("rst2_timeout",   {31'd0, timeout_o},   32'd0);
        check_val("rst2_boot_done", {31'd0, boot_done_o}, 32'd0);
        check_val("rst2_rdata",     sw_rdata_o,           32'd0);
        rst_i = 1'b0;
        tick();
        ack_dly      = 2;
        boot_start_i = 1'b1;
        tick();
        boot_start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (fll_ack_i && fll_req_o && fll_add_o == 2'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_val("lto_wr1_ack", {31'd0, found}, 32'd1);
        repeat (LOCK_TO) tick();
        check_val("lto_pre_done",    {31'd0, boot_done_o}, 32'd0);
        check_val("lto_pre_timeout", {31'd0, timeout_o},   32'd0);
        check_val("lto_pre_busy",    {31'd0, busy_o},      32'd1);
        tick();
        check_val("lto_done",    {31'd0, boot_done_o}, 32'd1);
        check_val("lto_timeout", {31'd0, timeout_o},   32'd1);
        check_val("lto_busy",    {31'd0, busy_o},      32'd0);

        // Reset in the middle of BOOT_WR1
        ack_dly      = 2;
        boot_start_i = 1'b1;
        tick();
        boot_start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (fll_req_o && fll_add_o == 2'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_val("mid_wr1_seen", {31'd0, found}, 32'd1);
        rst_i  = 1'b1;
        ack_en = 1'b0;
        tick();
        check_val("mid_fll_req",   {31'd0, fll_req_o},   32'd0);
        check_val("mid_fll_wrn",   {31'd0, fll_wrn_o},   32'd0);
        check_val("mid_fll_add",   {30'd0, fll_add_o},   32'd0);
        check_val("mid_fll_wdata", fll_wdata_o,          32'd0);
        check_val("mid_sw_ack",    {31'd0, sw_ack_o},    32'd0);
        check_val("mid_sw_err",    {31'd0, sw_err_o},    32'd0);
        check_val("mid_sw_rdata",  sw_rdata_o,           32'd0);
        check_val("mid_boot_done", {31'd0, boot_done_o}, 32'd0);
        check_val("mid_timeout",   {31'd0, timeout_o},   32'd0);
        check_val("mid_busy",      {31'd0, busy_o},      32'd0);
        rst_i  = 1'b0;
        ack_en = 1'b1;
        base   = wlog.size();
        n_req  = 0;
        n_ack  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fll_req_o) n_req++;
            if (sw_ack_o)  n_ack++;
        end
        check_val("mid_no_req",  n_req,       32'd0);
        check_val("mid_no_ack",  n_ack,       32'd0);
        check_val("mid_no_logs", wlog.size(), base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fll_cfg_sequencer.md
FLL_CFG_SEQUENCER -- requirements
Module: fll_cfg_sequencer

Interface
REQ-001 SHALL have parameter BOOT_CFG2, default 32'h0000_0000, boot value written to FLL register 2.
REQ-002 SHALL have parameter BOOT_CFG1, default 32'h0000_0100, boot value written to FLL register 1.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024, maximum cycles to wait for lock after boot writes.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 64, maximum cycles to wait for fll_ack_i per transfer.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk_i  input  1  clock; rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have the boot trigger port: boot_start_i  input  1  one-cycle pulse that requests the boot sequence.
REQ-007 SHALL have the software request ports: sw_req_i  input  1  request; sw_wrn_i  input  1  1=read, 0=write; sw_add_i  input  2  register address; sw_wdata_i  input  32  write data.
REQ-008 SHALL have the software response ports: sw_gnt_o  output  1  request accepted; sw_ack_o  output  1  transfer complete pulse; sw_rdata_o  output  32  read data; sw_err_o  output  1  ack timeout, valid with sw_ack_o.
REQ-009 SHALL have the FLL request ports: fll_req_o  output  1; fll_wrn_o  output  1; fll_add_o  output  2; fll_wdata_o  output  32.
REQ-010 SHALL have the FLL response ports: fll_ack_i  input  1; fll_rdata_i  input  32; fll_lock_i  input  1.
REQ-011 SHALL have the status ports: busy_o  output  1  FSM not in IDLE; boot_done_o  output  1  sticky, boot sequence finished; timeout_o  output  1  sticky, lock or ack timeout.

Function
REQ-012 SHALL implement states IDLE, SW_XFER, BOOT_WR2, BOOT_WR1, WAIT_LOCK.
REQ-013 In IDLE, if boot_start_i=1 or boot_pend=1, the FSM SHALL go to BOOT_WR2 and clear boot_pend; boot takes priority over software.
REQ-014 In IDLE with sw_req_i=1 and no boot trigger or pend, sw_gnt_o SHALL be 1 combinationally; wrn, add and wdata SHALL be captured; next state SW_XFER.
REQ-015 sw_gnt_o SHALL be 0 in every other case, including simultaneous boot_start_i and sw_req_i.
REQ-016 A boot_start_i pulse in any non-IDLE state SHALL set boot_pend, and the boot sequence SHALL be served on the next IDLE cycle.
REQ-017 In SW_XFER, BOOT_WR2 and BOOT_WR1, fll_req_o SHALL be 1 with registered wrn, add and wdata held stable until ack.
REQ-018 BOOT_WR2 and BOOT_WR1 SHALL drive wrn=0, with add=2 / wdata=BOOT_CFG2 and add=1 / wdata=BOOT_CFG1 respectively.
REQ-019 On the cycle fll_ack_i=1 is sampled, the FSM SHALL leave the transfer state, and fll_req_o SHALL be 0 the next cycle.
REQ-020 Transfer-state successors SHALL be: SW_XFER -> IDLE; BOOT_WR2 -> BOOT_WR1; BOOT_WR1 -> WAIT_LOCK.
REQ-021 On ack in SW_XFER, sw_ack_o SHALL pulse for exactly one cycle the next cycle, with sw_rdata_o=fll_rdata_i captured at ack when wrn=1, sw_rdata_o unchanged when wrn=0, and sw_err_o=0.
REQ-022 A per-transfer counter SHALL clear on entry to each transfer state.
REQ-023 If the per-transfer counter reaches ACK_TIMEOUT-1 without ack, the FSM SHALL deassert fll_req_o and set timeout_o.
REQ-024 On an ack timeout in SW_XFER, sw_ack_o=1 and sw_err_o=1 SHALL pulse together and the FSM SHALL return to IDLE.
REQ-025 On an ack timeout in a boot write, boot_done_o SHALL be set and the FSM SHALL go to IDLE.
REQ-026 In WAIT_LOCK, the lock counter SHALL clear on entry and increment each cycle.
REQ-027 In WAIT_LOCK, fll_lock_i=1 SHALL set boot_done_o and the FSM SHALL go to IDLE.
REQ-028 In WAIT_LOCK, reaching count LOCK_TIMEOUT-1 with fll_lock_i=0 SHALL set both boot_done_o and timeout_o and the FSM SHALL go to IDLE.
REQ-029 A new boot sequence SHALL clear boot_done_o on entry to BOOT_WR2; timeout_o SHALL clear only on reset.
REQ-030 Counters SHALL be sized to $clog2 of their timeout and SHALL saturate, never wrap.
REQ-031 busy_o SHALL equal (state != IDLE).

Reset
REQ-032 On a clock edge with rst_i=1, the FSM SHALL enter IDLE, including mid-transfer.
REQ-033 On that edge, fll_req_o, fll_wrn_o, fll_add_o, fll_wdata_o, sw_ack_o, sw_err_o, sw_rdata_o, boot_done_o, timeout_o, boot_pend and all counters SHALL become 0.
REQ-034 A transfer interrupted by reset SHALL NOT be retried and SHALL NOT produce sw_ack_o.

Verification
REQ-035 Boot sequence: boot_start_i pulse, fll_ack_i 2 cycles after each req, lock 10 cycles after the second ack -> writes (2, BOOT_CFG2) then (1, BOOT_CFG1), boot_done_o=1, timeout_o=0, busy_o=0.
REQ-036 Software read: sw_req_i, wrn=1, add=3, fll_rdata_i=32'hDEAD_BEEF, ack after 3 cycles -> sw_gnt_o same cycle, one sw_ack_o pulse, sw_rdata_o=32'hDEAD_BEEF, sw_err_o=0.
REQ-037 Simultaneous events: boot_start_i and sw_req_i in the same IDLE cycle -> sw_gnt_o=0, boot completes, then sw request granted in the first IDLE cycle.
REQ-038 Lock timeout: fll_lock_i held 0 -> boot_done_o=1 and timeout_o=1 exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry.
REQ-039 Ack timeout: no fll_ack_i on a sw write -> sw_ack_o=1 and sw_err_o=1 after ACK_TIMEOUT cycles, fll_req_o=0 the next cycle.
REQ-040 Reset mid-operation: rst_i asserted during BOOT_WR1 -> all outputs 0 after the edge, FSM idle, no further FLL requests.
